// File: rtl/mem_sweep_engine.sv
// mem_sweep_engine: self-contained memory write/read-back sweep engine.
// Pauses the CPU timer, writes a selectable pattern across an address window,
// reads it back through a one-stage compare pipeline and counts mismatches.
// Optional first-mismatch capture ports are enabled by defining MEM_SWEEP_ERRLOG_EN.
module mem_sweep_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 32768,
    parameter int BASE_ADDR  = 0,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            pattern_sel,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic                  cpu_pause,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_oe,
`ifdef MEM_SWEEP_ERRLOG_EN
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [DATA_WIDTH-1:0] first_err_exp,
    output logic [DATA_WIDTH-1:0] first_err_act,
`endif
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [ADDR_WIDTH-1:0] IDX_LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAUSE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [1:0]              pat_q;
    logic [DATA_WIDTH-1:0]   exp_q;
    logic                    cmp_pending_q;
    logic [ERR_WIDTH-1:0]    err_q, err_d;
    logic                    pass_q;
    logic                    mismatch;
    logic                    accept;
    logic                    aborting;

    // Pattern generator: all arithmetic wraps modulo 2^DATA_WIDTH
    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [1:0] sel,
                                                      input logic [ADDR_WIDTH-1:0] i);
        logic [DATA_WIDTH-1:0] cb;
        logic [DATA_WIDTH-1:0] r;
        for (int unsigned b = 0; b < DATA_WIDTH; b++) begin
            cb[b] = ~b[0];
        end
        case (sel)
            2'd0:    r = ~DATA_WIDTH'(i);
            2'd1:    r = DATA_WIDTH'(i);
            2'd2:    r = i[0] ? ~cb : cb;
            default: r = i[0] ? cb : ~cb;
        endcase
        return r;
    endfunction

    assign accept   = (state_q == S_IDLE) && start;
    assign aborting = (state_q != S_IDLE) && abort;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and memory-port decode; strobes follow the current state only
    always_comb begin
        state_d   = state_q;
        busy      = 1'b1;
        done      = 1'b0;
        mem_we    = 1'b0;
        mem_oe    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = BASE + idx_q;
                mem_wdata = pattern(pat_q, idx_q);
                if (idx_q == IDX_LAST) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                mem_oe   = 1'b1;
                mem_addr = BASE + idx_q;
                if (idx_q == IDX_LAST) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (aborting) begin
            state_d = S_IDLE;
        end
    end

    assign cpu_pause = busy;

    // Sweep index: advances once per access cycle, cleared between phases
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q <= '0;
        end else if (aborting) begin
            idx_q <= '0;
        end else if (state_q == S_WRITE || state_q == S_READ) begin
            idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + ADDR_WIDTH'(1);
        end else begin
            idx_q <= '0;
        end
    end

    // Pattern select is latched at start so the input may change mid-sweep
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q <= '0;
        end else if (accept) begin
            pat_q <= pattern_sel;
        end
    end

    // Expected-data stage: holds pattern(idx) for the compare one cycle later
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q         <= '0;
            cmp_pending_q <= 1'b0;
        end else begin
            cmp_pending_q <= (state_q == S_READ) && !abort;
            if (state_q == S_READ) begin
                exp_q <= pattern(pat_q, idx_q);
            end
        end
    end

    // Compare result and saturating next error count
    always_comb begin
        mismatch = cmp_pending_q && !abort && (mem_rdata != exp_q);
        err_d    = err_q;
        if (mismatch && (err_q != '1)) begin
            err_d = err_q + ERR_WIDTH'(1);
        end
    end

    // Error counter and pass flag; pass is resolved as DRAIN's final compare lands
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q  <= '0;
            pass_q <= 1'b0;
        end else if (accept) begin
            err_q  <= '0;
            pass_q <= 1'b0;
        end else if (aborting) begin
            pass_q <= 1'b0;
        end else begin
            err_q <= err_d;
            if (state_q == S_DRAIN) begin
                pass_q <= (err_d == '0);
            end
        end
    end

    assign err_count = err_q;
    assign pass      = pass_q;

`ifdef MEM_SWEEP_ERRLOG_EN
    logic [ADDR_WIDTH-1:0] exp_addr_q;

    // Address of the word whose read data is compared next cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_addr_q <= '0;
        end else if (state_q == S_READ) begin
            exp_addr_q <= mem_addr;
        end
    end

    // First-mismatch capture; err_q is still zero only for the first one
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            first_err_addr <= '0;
            first_err_exp  <= '0;
            first_err_act  <= '0;
        end else if (accept) begin
            first_err_addr <= '0;
            first_err_exp  <= '0;
            first_err_act  <= '0;
        end else if (mismatch && (err_q == '0)) begin
            first_err_addr <= exp_addr_q;
            first_err_exp  <= exp_q;
            first_err_act  <= mem_rdata;
        end
    end
`endif

endmodule
